// File: rtl/flop_array_pkg.sv
// flop_array_pkg: default parameters and the registered read-response type for flop_array_rf
package flop_array_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_DATA_N = 8;
    localparam int DEF_RD_P   = 2;
    localparam int DEF_ERR_W  = 4;
    localparam int RESP_DATA_W = 64;
    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [RESP_DATA_W-1:0] data;
    } rd_resp_t;
endpackage

// File: rtl/flop_array_rd_port.sv
// flop_array_rd_port: one read port, entry mux plus registered {valid, err, data} response
module flop_array_rd_port
    import flop_array_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_N = DEF_DATA_N
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rd,
    input  logic [ADDR_W-1:0] raddr,
    input  logic [DATA_N-1:0] valid,
    input  logic [DATA_W-1:0] mem [DATA_N],
    input  logic              byp,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              rerr,
    output logic              err_nxt
);
    localparam logic [ADDR_W:0] N = (ADDR_W+1)'(DATA_N);
    rd_resp_t resp_d, resp_q;
    logic hit;
    always_comb begin
        hit = ({1'b0, raddr} < N) && valid[raddr];
        resp_d = '0;
        resp_d.valid = rd && (byp || hit);
        resp_d.err = rd && !(byp || hit);
        resp_d.data = !resp_d.valid ? '0 : RESP_DATA_W'(byp ? wdata : mem[raddr]);
    end
    always_ff @(posedge clk) begin
        resp_q <= resetn ? resp_d : '0;
    end
    assign rvalid  = resp_q.valid;
    assign rerr    = resp_q.err;
    assign rdata   = resp_q.data[DATA_W-1:0];
    assign err_nxt = resp_d.err;
    a_excl: assert property (@(posedge clk) !(resp_q.valid && resp_q.err));
    a_zero: assert property (@(posedge clk) !resp_q.valid |-> resp_q.data == '0);
endmodule

// File: rtl/flop_array_rf.sv
// flop_array_rf: flop-based register file with valid bits, RD_P read ports and error counting
// FLOP_ARRAY_BYPASS_EN forwards same-cycle write data to matching read ports.
module flop_array_rf
    import flop_array_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_N = DEF_DATA_N,
    parameter int RD_P   = DEF_RD_P,
    parameter int ERR_W  = DEF_ERR_W
) (
    input  logic                           clk,
    input  logic                           resetn,
    input  logic                           wr,
    input  logic [ADDR_W-1:0]              waddr,
    input  logic [DATA_W-1:0]              wdata,
    input  logic                           inv,
    input  logic [ADDR_W-1:0]              iaddr,
    input  logic                           flush,
    input  logic [RD_P-1:0]                rd,
    input  logic [RD_P-1:0][ADDR_W-1:0]    raddr,
    output logic [RD_P-1:0][DATA_W-1:0]    rdata,
    output logic [RD_P-1:0]                rvalid,
    output logic [RD_P-1:0]                rerr,
    output logic                           werr,
    output logic [ERR_W-1:0]               err_cnt
);
    localparam logic [ADDR_W:0]  N       = (ADDR_W+1)'(DATA_N);
    localparam logic [ERR_W-1:0] CNT_MAX = '1;
    logic [DATA_W-1:0] mem [DATA_N];
    logic [DATA_N-1:0] valid;
    logic [RD_P-1:0]   byp;
    logic [RD_P-1:0]   rerr_nxt;
    logic              w_ok;
    logic              werr_nxt;
    logic [31:0]       cnt_sum;
    assign w_ok     = wr && ({1'b0, waddr} < N);
    assign werr_nxt = wr && !w_ok;
`ifdef FLOP_ARRAY_BYPASS_EN
    always_comb begin
        for (int p = 0; p < RD_P; p++)
            byp[p] = w_ok && (raddr[p] == waddr);
    end
`else
    assign byp = '0;
`endif
    always_ff @(posedge clk) begin
        if (w_ok) mem[waddr] <= wdata;
    end
    // a write to an entry wins over a same-cycle inv or flush
    always_ff @(posedge clk) begin
        if (!resetn) valid <= '0;
        else
            for (int i = 0; i < DATA_N; i++)
                if (w_ok && waddr == ADDR_W'(i)) valid[i] <= 1'b1;
                else if ((inv && iaddr == ADDR_W'(i)) || flush) valid[i] <= 1'b0;
    end
    always_comb begin
        cnt_sum = 32'(err_cnt) + 32'($countones({rerr_nxt, werr_nxt}));
    end
    always_ff @(posedge clk) begin
        werr    <= resetn && werr_nxt;
        err_cnt <= !resetn ? '0 : (cnt_sum > 32'(CNT_MAX)) ? CNT_MAX : cnt_sum[ERR_W-1:0];
    end
    for (genvar p = 0; p < RD_P; p++) begin : g_rd
        flop_array_rd_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DATA_N(DATA_N)) u_rd (
            .clk     (clk),
            .resetn  (resetn),
            .rd      (rd[p]),
            .raddr   (raddr[p]),
            .valid   (valid),
            .mem     (mem),
            .byp     (byp[p]),
            .wdata   (wdata),
            .rdata   (rdata[p]),
            .rvalid  (rvalid[p]),
            .rerr    (rerr[p]),
            .err_nxt (rerr_nxt[p])
        );
    end
    a_cnt_mono: assert property (@(posedge clk) resetn |=> err_cnt >= $past(err_cnt));
endmodule

// File: tb/tb_flop_array_rf.sv
// tb_flop_array_rf: directed and randomized checks of flop_array_rf (DATA_N=6) against a behavioural model
module tb_flop_array_rf;
    localparam int DW = 8, AW = 3, N = 6, RP = 2, EW = 4;
    localparam int CMAX = 2**EW - 1;
    logic clk = 1'b0;
    logic resetn, wr, inv, flush, werr;
    logic [AW-1:0] waddr, iaddr;
    logic [DW-1:0] wdata;
    logic [RP-1:0] rd, rvalid, rerr;
    logic [RP-1:0][AW-1:0] raddr;
    logic [RP-1:0][DW-1:0] rdata;
    logic [EW-1:0] err_cnt;
    int checks = 0, failures = 0;
    logic [DW-1:0] m_data [N];
    logic          m_valid [N];
    int            m_cnt;
    logic [RP-1:0] e_rvalid, e_rerr;
    logic [RP-1:0][DW-1:0] e_rdata;
    logic          e_werr;

    flop_array_rf #(.DATA_W(DW), .ADDR_W(AW), .DATA_N(N), .RD_P(RP), .ERR_W(EW)) dut (
        .clk(clk), .resetn(resetn), .wr(wr), .waddr(waddr), .wdata(wdata),
        .inv(inv), .iaddr(iaddr), .flush(flush), .rd(rd), .raddr(raddr),
        .rdata(rdata), .rvalid(rvalid), .rerr(rerr), .werr(werr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [24:0] got();
        return {rvalid, rerr, rdata, werr, err_cnt};
    endfunction

    function automatic logic [24:0] want();
        return {e_rvalid, e_rerr, e_rdata, e_werr, EW'(m_cnt)};
    endfunction

    task automatic idle();
        wr = 0; inv = 0; flush = 0; rd = '0;
    endtask

    // model: expected responses come from the contents before this edge's write/inv/flush
    task automatic step();
        int pulses;
        logic byp;
        e_rvalid = '0; e_rerr = '0; e_rdata = '0; e_werr = 0; pulses = 0;
        if (!resetn) begin
            m_cnt = 0;
            for (int i = 0; i < N; i++) m_valid[i] = 0;
        end else begin
            for (int p = 0; p < RP; p++) begin
                if (rd[p]) begin
                    byp = 0;
`ifdef FLOP_ARRAY_BYPASS_EN
                    byp = wr && int'(waddr) < N && waddr == raddr[p];
`endif
                    if (byp) begin
                        e_rvalid[p] = 1; e_rdata[p] = wdata;
                    end else if (int'(raddr[p]) < N && m_valid[raddr[p]]) begin
                        e_rvalid[p] = 1; e_rdata[p] = m_data[raddr[p]];
                    end else begin
                        e_rerr[p] = 1; pulses++;
                    end
                end
            end
            e_werr = wr && int'(waddr) >= N;
            pulses += int'(e_werr);
            m_cnt = (m_cnt + pulses > CMAX) ? CMAX : m_cnt + pulses;
            for (int i = 0; i < N; i++) begin
                if (wr && int'(waddr) == i) begin
                    m_valid[i] = 1; m_data[i] = wdata;
                end else if ((inv && int'(iaddr) == i) || flush) m_valid[i] = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 0; idle(); rd = 2'b11; raddr[0] = 3'd0; raddr[1] = 3'd4;
        wdata = '0; waddr = '0; iaddr = '0;
        step(); step();
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL reset_model got=%h want=%h", got(), want()); end
        checks++;
        if (got() !== 25'd0) begin failures++; $display("FAIL reset_zero got=%h want=0", got()); end
        resetn = 1; idle(); step();
        checks++;
        if (got() !== 25'd0) begin failures++; $display("FAIL reset_discard got=%h want=0", got()); end
    endtask

    task automatic test_read_invalid();
        idle(); rd = 2'b01; raddr[0] = 3'd3; step();
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL rd_invalid_model got=%h want=%h", got(), want()); end
        checks++;
        if ({rvalid, rerr, rdata[0], err_cnt} !== {2'b00, 2'b01, 8'h00, 4'd1}) begin
            failures++; $display("FAIL rd_invalid got=%h want=%h", {rvalid, rerr, rdata[0], err_cnt}, {2'b00, 2'b01, 8'h00, 4'd1});
        end
    endtask

    task automatic test_dual_read();
        idle(); wr = 1; waddr = 3'd5; wdata = 8'hA5; step();
        idle(); rd = 2'b11; raddr[0] = 3'd5; raddr[1] = 3'd5; step();
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL dual_model got=%h want=%h", got(), want()); end
        checks++;
        if ({rvalid, rdata} !== {2'b11, 8'hA5, 8'hA5}) begin
            failures++; $display("FAIL dual_read got=%h want=%h", {rvalid, rdata}, {2'b11, 8'hA5, 8'hA5});
        end
    endtask

    task automatic test_write_flush();
        idle(); wr = 1; waddr = 3'd2; wdata = 8'h3C; flush = 1; step();
        idle(); rd = 2'b11; raddr[0] = 3'd2; raddr[1] = 3'd5; step();
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL flush_model got=%h want=%h", got(), want()); end
        checks++;
        if ({rvalid, rerr, rdata[0]} !== {2'b01, 2'b10, 8'h3C}) begin
            failures++; $display("FAIL write_flush got=%h want=%h", {rvalid, rerr, rdata[0]}, {2'b01, 2'b10, 8'h3C});
        end
    endtask

    task automatic test_same_cycle();
        logic [11:0] exp;
        idle(); inv = 1; iaddr = 3'd1; step();
        idle(); wr = 1; waddr = 3'd1; wdata = 8'h77; rd = 2'b01; raddr[0] = 3'd1; step();
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL same_cycle_model got=%h want=%h", got(), want()); end
`ifdef FLOP_ARRAY_BYPASS_EN
        exp = {2'b01, 2'b00, 8'h77};
`else
        exp = {2'b00, 2'b01, 8'h00};
`endif
        checks++;
        if ({rvalid, rerr, rdata[0]} !== exp) begin
            failures++; $display("FAIL same_cycle got=%h want=%h", {rvalid, rerr, rdata[0]}, exp);
        end
        idle(); wr = 1; waddr = 3'd1; wdata = 8'h12; rd = 2'b01; raddr[0] = 3'd1; step();
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL rd_during_wr got=%h want=%h", got(), want()); end
        idle(); rd = 2'b01; raddr[0] = 3'd1; step();
        checks++;
        if ({rvalid[0], rdata[0]} !== {1'b1, 8'h12}) begin
            failures++; $display("FAIL after_wr got=%h want=%h", {rvalid[0], rdata[0]}, {1'b1, 8'h12});
        end
    endtask

    task automatic test_out_of_range();
        idle(); wr = 1; waddr = 3'd7; wdata = 8'hFF; step();
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL werr_model got=%h want=%h", got(), want()); end
        checks++;
        if (werr !== 1'b1) begin failures++; $display("FAIL werr got=%b want=1", werr); end
        idle(); inv = 1; iaddr = 3'd7; rd = 2'b11; raddr[0] = 3'd2; raddr[1] = 3'd1; step();
        checks++;
        if (got() !== want()) begin failures++; $display("FAIL oob_unchanged_model got=%h want=%h", got(), want()); end
        checks++;
        if ({werr, rvalid, rerr, rdata} !== {1'b0, 2'b11, 2'b00, 8'h12, 8'h3C}) begin
            failures++; $display("FAIL oob_unchanged got=%h want=%h", {werr, rvalid, rerr, rdata}, {1'b0, 2'b11, 2'b00, 8'h12, 8'h3C});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            resetn = ($urandom % 40) != 0;
            wr = 1'($urandom); waddr = AW'($urandom); wdata = DW'($urandom);
            inv = ($urandom % 4) == 0; iaddr = AW'($urandom);
            flush = ($urandom % 16) == 0;
            rd = RP'($urandom); raddr[0] = AW'($urandom); raddr[1] = AW'($urandom);
            step();
            checks++;
            if (got() !== want()) begin failures++; $display("FAIL random c=%0d got=%h want=%h", c, got(), want()); end
        end
        resetn = 1;
    endtask

    task automatic test_saturation();
        resetn = 0; idle(); step();
        resetn = 1;
        for (int c = 0; c < 20; c++) begin
            idle(); wr = 1; waddr = 3'd7; step();
            checks++;
            if (got() !== want()) begin failures++; $display("FAIL sat c=%0d got=%h want=%h", c, got(), want()); end
        end
        checks++;
        if (err_cnt !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d want=15", err_cnt); end
    endtask

    initial begin
        test_reset();
        test_read_invalid();
        test_dual_read();
        test_write_flush();
        test_same_cycle();
        test_out_of_range();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flop_array_rf.md
FLOP_ARRAY_RF -- requirements
Module: flop_array_rf

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per entry.
REQ-002 SHALL have parameter ADDR_W, default 3, address bits.
REQ-003 SHALL have parameter DATA_N, default 8, entry count; legal range 2..2**ADDR_W.
REQ-004 SHALL have parameter RD_P, default 2, number of independent read ports.
REQ-005 SHALL have parameter ERR_W, default 4, error counter width.
REQ-006 SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock; resetn  in  1  sync active-low reset.
REQ-007 SHALL have ports wr  in  1  write strobe; waddr  in  ADDR_W  write address; wdata  in  DATA_W  write data.
REQ-008 SHALL have ports inv  in  1  invalidate strobe; iaddr  in  ADDR_W  invalidate address; flush  in  1  invalidate all entries.
REQ-009 SHALL have ports rd  in  RD_P  per-port read strobe; raddr  in  RD_P x ADDR_W  per-port read address.
REQ-010 SHALL have ports rdata  out  RD_P x DATA_W  read data; rvalid  out  RD_P  read data valid; rerr  out  RD_P  read error pulse.
REQ-011 SHALL have ports werr  out  1  write error pulse; err_cnt  out  ERR_W  saturating error count.

Function
REQ-012 SHALL hold one valid bit per entry; a write sets it, inv or flush clears it.
REQ-013 SHALL write wdata into entry waddr at the clock edge when wr=1 and waddr<DATA_N.
REQ-014 SHALL return read data one cycle after rd: rvalid[p]=1, rdata[p]=entry contents when the entry was valid at the rd edge.
REQ-015 SHALL drive rdata[p]=0 whenever rvalid[p]=0.
REQ-016 SHALL, for a read of an invalid entry or raddr>=DATA_N, pulse rerr[p] for one cycle one cycle after rd; rvalid[p]=0.
REQ-017 SHALL, for wr with waddr>=DATA_N, ignore the write and pulse werr one cycle later.
REQ-018 SHALL serve all RD_P ports in the same cycle, including identical addresses, with no arbitration.
REQ-019 SHALL give priority write > inv > flush per entry: an entry written in the same cycle as inv to the same address or flush remains valid with the new data.
REQ-020 SHALL treat inv with iaddr>=DATA_N as a no-op without error.
REQ-021 SHALL increment err_cnt by the number of rerr/werr pulses asserted in a cycle, saturating at 2**ERR_W-1.
REQ-022 SHALL, for a read of the address being written in the same cycle without bypass, return the pre-write contents and valid state.

Reset
REQ-023 SHALL, with resetn=0 at a clock edge, clear all valid bits, rvalid, rerr, werr, rdata and err_cnt to 0.
REQ-024 SHALL not reset entry data storage; data is unobservable until rewritten.
REQ-025 SHALL discard reads issued in the cycle reset is asserted; no rvalid or rerr follows.

Configuration
REQ-026 SHALL, with FLOP_ARRAY_BYPASS_EN defined, forward wdata to a read port whose raddr equals a valid in-range waddr in the same cycle: rvalid=1 next cycle, rdata=wdata.
REQ-027 SHALL, without FLOP_ARRAY_BYPASS_EN, behave per REQ-022.

Structure
REQ-028 SHALL place the default parameter constants and a read-response struct {valid, err, data} in package flop_array_pkg.
REQ-029 SHALL implement the per-port read mux and response register in sub-module flop_array_rd_port, instantiated RD_P times.
REQ-030 SHALL carry assertions: rvalid and rerr never both set on one port; rdata=0 when rvalid=0; err_cnt never decreases except on reset.

Verification
REQ-031 SHALL cover reset then rd port0 raddr=3 -> rerr[0]=1, rvalid[0]=0, rdata[0]=0, err_cnt=1.
REQ-032 SHALL cover wr waddr=5 wdata=0xA5, next cycle rd both ports raddr=5 -> next cycle rvalid=2'b11, rdata=0xA5 on both.
REQ-033 SHALL cover wr waddr=2 wdata=0x3C with flush in the same cycle, then rd raddr=2 -> rvalid=1, rdata=0x3C; any other address -> rerr.
REQ-034 SHALL cover wr waddr=1 wdata=0x77 with rd raddr=1 in the same cycle on an invalid entry -> bypass build: rvalid=1, rdata=0x77; non-bypass build: rerr=1.
REQ-035 SHALL cover DATA_N=6: wr waddr=7 -> werr=1, no entry changed; 20 consecutive error events with ERR_W=4 -> err_cnt holds at 15.
